ebr_write_scheduler: RTL

//   Shares one EBR write port between NUM_REQ pulse-style writers (i2c memory writer, SPI loader, ...).

---
 rtl/ebr_write_scheduler_pkg.sv | 9 +
 rtl/ebr_write_scheduler_if.sv | 32 +++
 rtl/ebr_write_scheduler_slot.sv | 61 ++++++
 rtl/ebr_write_scheduler.sv | 88 ++++++++
 4 files changed

// File: rtl/ebr_write_scheduler_pkg.sv
// ebr_write_scheduler_pkg: shared widths and round-robin index helper for the EBR write scheduler
package ebr_write_scheduler_pkg;
  localparam int EBR_ADDR_WIDTH = 8;
  localparam int EBR_DATA_WIDTH = 8;
  localparam int GRANT_ID_WIDTH = 2;
  function automatic int rr_index(input logic [GRANT_ID_WIDTH-1:0] base, input int k, input int n);
    return (int'(base) + k) % n;
  endfunction
endpackage

// File: rtl/ebr_write_scheduler_if.sv
// ebr_write_scheduler_if: writer-side request bus and EBR-side write port of the scheduler
//   req_start/req_wren/req_select/req_addr/req_data, overflow_clear : writers -> scheduler
//   ebr_wren/ebr_select/ebr_addr/ebr_data/ebr_grant_id, overflow, busy : scheduler -> EBR / status
interface ebr_write_scheduler_if
  import ebr_write_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_WIDTH = EBR_ADDR_WIDTH,
  parameter int DATA_WIDTH = EBR_DATA_WIDTH
);
  logic [NUM_REQ-1:0] req_start;
  logic [NUM_REQ-1:0] req_wren;
  logic [NUM_REQ-1:0] req_select;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic overflow_clear;
  logic ebr_wren;
  logic ebr_select;
  logic [ADDR_WIDTH-1:0] ebr_addr;
  logic [DATA_WIDTH-1:0] ebr_data;
  logic [GRANT_ID_WIDTH-1:0] ebr_grant_id;
  logic [NUM_REQ-1:0] overflow;
  logic busy;
  modport master (
    output req_start, req_wren, req_select, req_addr, req_data, overflow_clear,
    input ebr_wren, ebr_select, ebr_addr, ebr_data, ebr_grant_id, overflow, busy
  );
  modport slave (
    input req_start, req_wren, req_select, req_addr, req_data, overflow_clear,
    output ebr_wren, ebr_select, ebr_addr, ebr_data, ebr_grant_id, overflow, busy
  );
endinterface

// File: rtl/ebr_write_scheduler_slot.sv
// ebr_write_slot: one writer's 1-entry holding slot with address auto-increment and sticky overflow
//   start_i/wren_i/select_i/base_i/data_i : writer pulse and payload
//   grant_i : slot is being drained this cycle;  clear_i : clear overflow
//   pending_o/select_o/addr_o/data_o : slot contents;  overflow_o : byte was dropped
module ebr_write_slot
  import ebr_write_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH = EBR_ADDR_WIDTH,
  parameter int DATA_WIDTH = EBR_DATA_WIDTH
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start_i,
  input  logic wren_i,
  input  logic select_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic grant_i,
  input  logic clear_i,
  output logic pending_o,
  output logic select_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic overflow_o
);
  logic [ADDR_WIDTH-1:0] offset_q, offset_d, off_eff, addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic pending_q, pending_d, select_q, select_d, overflow_q, overflow_d, accept;
  // start takes effect before a same-cycle wren, so that byte lands at offset 0
  always_comb begin
    off_eff = start_i ? '0 : offset_q;
    accept = wren_i && (!pending_q || grant_i);
    offset_d = wren_i ? off_eff + 1'b1 : off_eff;
    pending_d = accept || (pending_q && !grant_i);
    select_d = accept ? select_i : select_q;
    addr_d = accept ? base_i + off_eff : addr_q;
    data_d = accept ? data_i : data_q;
    overflow_d = (wren_i && pending_q && !grant_i) || (overflow_q && !clear_i);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      offset_q <= '0;
      pending_q <= 1'b0;
      select_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      offset_q <= offset_d;
      pending_q <= pending_d;
      select_q <= select_d;
      addr_q <= addr_d;
      data_q <= data_d;
      overflow_q <= overflow_d;
    end
  assign pending_o = pending_q;
  assign select_o = select_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign overflow_o = overflow_q;
endmodule

// File: rtl/ebr_write_scheduler.sv
// ebr_write_scheduler: round-robin sharing of one EBR write port among pulse-style writers
//   clock, reset_n (async active-low) : plain ports
//   bus (slave modport) : per-writer requests in, registered EBR write strobe/payload out,
//                         sticky per-writer overflow, combinational busy
module ebr_write_scheduler
  import ebr_write_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_WIDTH = EBR_ADDR_WIDTH,
  parameter int DATA_WIDTH = EBR_DATA_WIDTH
) (
  input logic clock,
  input logic reset_n,
  ebr_write_scheduler_if.slave bus
);
  logic [NUM_REQ-1:0] pend, sel, grant, ovf;
  logic [ADDR_WIDTH-1:0] s_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] s_data [NUM_REQ];
  logic [GRANT_ID_WIDTH-1:0] rr_q, gnt_id, id_q;
  logic gnt_valid, wren_q, sel_q, m_sel;
  logic [ADDR_WIDTH-1:0] addr_q, m_addr;
  logic [DATA_WIDTH-1:0] data_q, m_data;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    ebr_write_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clock(clock),
      .reset_n(reset_n),
      .start_i(bus.req_start[g]),
      .wren_i(bus.req_wren[g]),
      .select_i(bus.req_select[g]),
      .base_i(bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .data_i(bus.req_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .grant_i(grant[g]),
      .clear_i(bus.overflow_clear),
      .pending_o(pend[g]),
      .select_o(sel[g]),
      .addr_o(s_addr[g]),
      .data_o(s_data[g]),
      .overflow_o(ovf[g])
    );
    assign grant[g] = gnt_valid && (gnt_id == GRANT_ID_WIDTH'(g));
  end
  // search starts one past the last winner so every pending writer is reached within NUM_REQ grants
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id = '0;
    for (int k = 1; k <= NUM_REQ; k++)
      if (!gnt_valid && pend[rr_index(rr_q, k, NUM_REQ)]) begin
        gnt_valid = 1'b1;
        gnt_id = GRANT_ID_WIDTH'(rr_index(rr_q, k, NUM_REQ));
      end
  end
  always_comb begin
    m_sel = 1'b0;
    m_addr = '0;
    m_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        m_sel = sel[i];
        m_addr = s_addr[i];
        m_data = s_data[i];
      end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rr_q <= GRANT_ID_WIDTH'(NUM_REQ - 1);
      wren_q <= 1'b0;
      sel_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      id_q <= '0;
    end else begin
      wren_q <= gnt_valid;
      if (gnt_valid) begin
        rr_q <= gnt_id;
        sel_q <= m_sel;
        addr_q <= m_addr;
        data_q <= m_data;
        id_q <= gnt_id;
      end
    end
  assign bus.ebr_wren = wren_q;
  assign bus.ebr_select = sel_q;
  assign bus.ebr_addr = addr_q;
  assign bus.ebr_data = data_q;
  assign bus.ebr_grant_id = id_q;
  assign bus.overflow = ovf;
  assign bus.busy = |pend;
endmodule
